// File: rtl/sound_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sound_pkg
// Description : Note half-periods, source and FSM encodings for the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sound_pkg;

    localparam int HP_W = 22;

    // Half-period registers hold cycles/2 - 1 at 25 MHz.
    localparam logic [HP_W-1:0] HP_WALL   = 22'd28408;
    localparam logic [HP_W-1:0] HP_PADDLE = 22'd14204;
    localparam logic [HP_W-1:0] HP_SCORE0 = 22'd18938;
    localparam logic [HP_W-1:0] HP_SCORE1 = 22'd37877;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_WALL   = 2'd1,
        SRC_PADDLE = 2'd2,
        SRC_SCORE  = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [HP_W-1:0] note_half_period(input src_t src, input logic idx);
        logic [HP_W-1:0] hp;
        hp = '0;
        case (src)
            SRC_WALL:   hp = HP_WALL;
            SRC_PADDLE: hp = HP_PADDLE;
            SRC_SCORE:  hp = idx ? HP_SCORE1 : HP_SCORE0;
            default:    hp = '0;
        endcase
        return hp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sound_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sound_sequencer_if
// Description : Game-event requests in, tone-generator controls out.
// Revision    : 1.0 - initial release
// ============================================================================
interface sound_sequencer_if;
    import sound_pkg::*;

    logic            req_wall;
    logic            req_paddle;
    logic            req_score;
    logic [HP_W-1:0] half_period;
    logic            tone_en;
    logic            busy;
    logic [1:0]      active_src;

    modport master (
        output req_wall, req_paddle, req_score,
        input  half_period, tone_en, busy, active_src
    );

    modport slave (
        input  req_wall, req_paddle, req_score,
        output half_period, tone_en, busy, active_src
    );
endinterface
`default_nettype wire

// File: rtl/sound_sequencer_ms_ticker.sv
`default_nettype none
// ============================================================================
// Module      : ms_ticker
// Description : Restartable 0..TICK_CYCLES-1 counter with a wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_ticker #(
    parameter int TICK_CYCLES = 25000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_restart,
    output logic      o_tick
);
    localparam int c_CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICK_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_LAST);
    assign o_tick = w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sound_sequencer
// Description : Latches pong sound events, grants by priority, plays notes.
// Revision    : 1.0 - initial release
// ============================================================================
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int TICK_CYCLES = 25000,
    parameter int WALL_MS     = 30,
    parameter int PADDLE_MS   = 50,
    parameter int SCORE_MS    = 150,
    parameter int GAP_MS      = 10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sound_sequencer_if.slave  bus
);
    localparam logic [7:0] c_WALL_DUR   = 8'(WALL_MS);
    localparam logic [7:0] c_PADDLE_DUR = 8'(PADDLE_MS);
    localparam logic [7:0] c_SCORE_DUR  = 8'(SCORE_MS);
    localparam logic [7:0] c_GAP_DUR    = 8'(GAP_MS);

    // Pending bit order: [0] wall, [1] paddle, [2] score.
    logic [2:0]      r_pend;
    state_t          r_state;
    src_t            r_active_src;
    logic            r_note_idx;
    logic [7:0]      r_dur;
    logic [HP_W-1:0] r_half_period;
    logic            r_tone_en;
    logic            r_busy;

    logic [2:0]      w_req;
    logic [2:0]      w_clr;
    src_t            w_grant_src;
    logic [7:0]      w_grant_dur;
    logic            w_tick;
    logic            w_last_tick;
    logic            w_restart;

    assign w_req = {bus.req_score, bus.req_paddle, bus.req_wall};

    always_comb begin
        w_grant_src = SRC_NONE;
        w_grant_dur = 8'd0;
        w_clr       = 3'b000;
        if (r_pend[2]) begin
            w_grant_src = SRC_SCORE;
            w_grant_dur = c_SCORE_DUR;
        end else if (r_pend[1]) begin
            w_grant_src = SRC_PADDLE;
            w_grant_dur = c_PADDLE_DUR;
        end else if (r_pend[0]) begin
            w_grant_src = SRC_WALL;
            w_grant_dur = c_WALL_DUR;
        end
        if (r_state == ST_IDLE) begin
            case (w_grant_src)
                SRC_WALL:   w_clr = 3'b001;
                SRC_PADDLE: w_clr = 3'b010;
                SRC_SCORE:  w_clr = 3'b100;
                default:    w_clr = 3'b000;
            endcase
        end
    end

    // The ticker is held at zero in IDLE so every PLAY/GAP entry starts a fresh ms.
    assign w_last_tick = w_tick && (r_dur <= 8'd1);
    assign w_restart   = (r_state == ST_IDLE) || w_last_tick;

    ms_ticker #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_ticker (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend        <= 3'b000;
            r_state       <= ST_IDLE;
            r_active_src  <= SRC_NONE;
            r_note_idx    <= 1'b0;
            r_dur         <= 8'd0;
            r_half_period <= '0;
            r_tone_en     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // A request coinciding with its own grant survives the clear.
            r_pend <= (r_pend & ~w_clr) | w_req;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_src != SRC_NONE) begin
                        r_state       <= ST_PLAY;
                        r_active_src  <= w_grant_src;
                        r_note_idx    <= 1'b0;
                        r_half_period <= note_half_period(w_grant_src, 1'b0);
                        r_dur         <= w_grant_dur;
                        r_tone_en     <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_last_tick) begin
                        r_state   <= ST_GAP;
                        r_dur     <= c_GAP_DUR;
                        r_tone_en <= 1'b0;
                    end else if (w_tick) begin
                        r_dur <= r_dur - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (w_last_tick) begin
                        if (r_active_src == SRC_SCORE && !r_note_idx) begin
                            r_state       <= ST_PLAY;
                            r_note_idx    <= 1'b1;
                            r_half_period <= note_half_period(SRC_SCORE, 1'b1);
                            r_dur         <= c_SCORE_DUR;
                            r_tone_en     <= 1'b1;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_active_src <= SRC_NONE;
                            r_busy       <= 1'b0;
                        end
                    end else if (w_tick) begin
                        r_dur <= r_dur - 8'd1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_active_src <= SRC_NONE;
                    r_tone_en    <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.half_period = r_half_period;
    assign bus.tone_en     = r_tone_en;
    assign bus.busy        = r_busy;
    assign bus.active_src  = r_active_src;
endmodule
`default_nettype wire

// File: tb/tb_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sound_sequencer
// Description : Directed self-checking bench for sound_sequencer, TICK_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    sound_sequencer_if bus ();

    sound_sequencer #(
        .TICK_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},    32'(bus.busy),       32'd0);
        check({tag, " tone_en"}, 32'(bus.tone_en),    32'd0);
        check({tag, " src"},     32'(bus.active_src), 32'd0);
    endtask

    task automatic check_note(input string tag, input int src, input int hp);
        check({tag, " tone_en"}, 32'(bus.tone_en),     32'd1);
        check({tag, " busy"},    32'(bus.busy),        32'd1);
        check({tag, " src"},     32'(bus.active_src),  32'(src));
        check({tag, " hp"},      32'(bus.half_period), 32'(hp));
    endtask

    // Drive a one-cycle request; returns at the negedge after the sampling edge.
    task automatic pulse_req(input int which);
        if (which == 1) bus.req_wall   = 1'b1;
        if (which == 2) bus.req_paddle = 1'b1;
        if (which == 3) bus.req_score  = 1'b1;
        @(negedge clk);
        bus.req_wall   = 1'b0;
        bus.req_paddle = 1'b0;
        bus.req_score  = 1'b0;
    endtask

    task automatic measure_tone(output int n);
        n = 0;
        while (bus.tone_en === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic measure_gap(output int n);
        n = 0;
        while (bus.busy === 1'b1 && bus.tone_en === 1'b0 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int cnt;
        logic seen;

        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.req_wall   = 1'b0;
        bus.req_paddle = 1'b0;
        bus.req_score  = 1'b0;

        // 1: reset and idle
        repeat (3) @(negedge clk);
        check_idle("t1 reset");
        check("t1 reset hp", 32'(bus.half_period), 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_idle("t1 idle100");
        check("t1 idle100 hp", 32'(bus.half_period), 32'd0);

        // 2: single paddle event
        pulse_req(2);
        check("t2 latch cycle busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_note("t2 first", 2, 14204);
        measure_tone(n);
        check("t2 tone len", 32'(n), 32'd200);
        check("t2 gap hp held", 32'(bus.half_period), 32'd14204);
        check("t2 gap src", 32'(bus.active_src), 32'd2);
        measure_gap(n);
        check("t2 gap len", 32'(n), 32'd40);
        check_idle("t2 end");

        // 3: simultaneous events, priority score > paddle > wall
        repeat (5) @(negedge clk);
        bus.req_wall   = 1'b1;
        bus.req_paddle = 1'b1;
        pulse_req(3);
        @(negedge clk);
        check_note("t3 score0", 3, 18938);
        measure_tone(n);
        check("t3 score0 len", 32'(n), 32'd600);
        check("t3 gap1 hp held", 32'(bus.half_period), 32'd18938);
        measure_gap(n);
        check("t3 gap1 len", 32'(n), 32'd40);
        check_note("t3 score1", 3, 37877);
        measure_tone(n);
        check("t3 score1 len", 32'(n), 32'd600);
        measure_gap(n);
        check("t3 gap2 len", 32'(n), 32'd40);
        check_idle("t3 idle after score");
        @(negedge clk);
        check_note("t3 paddle", 2, 14204);
        measure_tone(n);
        check("t3 paddle len", 32'(n), 32'd200);
        measure_gap(n);
        check("t3 paddle gap", 32'(n), 32'd40);
        check_idle("t3 idle after paddle");
        @(negedge clk);
        check_note("t3 wall", 1, 28408);
        measure_tone(n);
        check("t3 wall len", 32'(n), 32'd120);
        measure_gap(n);
        check("t3 wall gap", 32'(n), 32'd40);
        check_idle("t3 end");
        @(negedge clk);
        check_idle("t3 nothing pending");

        // 4: wall held 3 cycles then re-pulsed mid-note -> exactly two sequences
        repeat (5) @(negedge clk);
        bus.req_wall = 1'b1;
        @(negedge clk);
        check("t4 latch cycle busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_note("t4 first", 1, 28408);
        cnt = 1;
        for (int i = 0; i < 5000; i++) begin
            if (cnt == 2)  bus.req_wall = 1'b0;
            if (cnt == 20) bus.req_wall = 1'b1;
            if (cnt == 21) bus.req_wall = 1'b0;
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            cnt++;
        end
        check("t4 seq1 busy len", 32'(cnt), 32'd160);
        check_idle("t4 idle gap");
        @(negedge clk);
        check_note("t4 second", 1, 28408);
        cnt = 1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            cnt++;
        end
        check("t4 seq2 busy len", 32'(cnt), 32'd160);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) seen = 1'b1;
        end
        check("t4 no third seq", 32'(seen), 32'd0);

        // 5: score requested during a wall note waits for the wall to finish
        pulse_req(1);
        @(negedge clk);
        check_note("t5 wall", 1, 28408);
        cnt = 1;
        for (int i = 0; i < 5000; i++) begin
            if (cnt == 30) bus.req_score = 1'b1;
            if (cnt == 31) bus.req_score = 1'b0;
            @(negedge clk);
            if (bus.tone_en !== 1'b1) break;
            check("t5 wall hp steady", 32'(bus.half_period), 32'd28408);
            cnt++;
        end
        check("t5 wall len", 32'(cnt), 32'd120);
        check("t5 gap src", 32'(bus.active_src), 32'd1);
        measure_gap(n);
        check("t5 wall gap", 32'(n), 32'd40);
        check_idle("t5 idle");
        @(negedge clk);
        check_note("t5 score", 3, 18938);

        // 6: asynchronous reset mid score note drops pending work
        repeat (50) @(negedge clk);
        pulse_req(1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("t6 async reset");
        check("t6 async reset hp", 32'(bus.half_period), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.tone_en !== 1'b0) seen = 1'b1;
        end
        check("t6 nothing replays", 32'(seen), 32'd0);
        pulse_req(2);
        @(negedge clk);
        check_note("t6 new request", 2, 14204);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sound_sequencer.md
# sound_sequencer

Arbitrates game sound events for the pong design and sequences the tone generator. Wall-bounce, paddle-hit and score events from the game logic each request a short sound. The block latches the requests, grants them by fixed priority, and plays one note or a two-note phrase per event. It drives the tone generator's 22-bit half-period input plus a gate that the top level ANDs with the buzzer output.

## Interface
- TICK_CYCLES, 25000: clock cycles per 1 ms tick (25 MHz clk).
- WALL_MS, 30: wall note length in ticks.
- PADDLE_MS, 50: paddle note length in ticks.
- SCORE_MS, 150: length of each score note in ticks.
- GAP_MS, 10: silent gap after every note, in ticks.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_wall  in  1  wall-bounce event, single-cycle pulse or level.
- req_paddle  in  1  paddle-hit event.
- req_score  in  1  point-scored event.
- half_period  out  22  cycles-minus-one per half period; feeds the tone generator counter input.
- tone_en  out  1  high while a note sounds.
- busy  out  1  high whenever state is not IDLE.
- active_src  out  2  source being played: 0 none, 1 wall, 2 paddle, 3 score.

## Operation
- Pending latches, one per source. A latch sets on any cycle its req is high. It clears on the grant edge of that source. If set and clear coincide, set wins. Repeated requests while a latch is pending coalesce into one.
- Priority: score > paddle > wall. There is no preemption. A sequence in progress always completes, including its final gap.
- FSM has three states: IDLE, PLAY and GAP.
  - IDLE → PLAY when any latch is pending. The winner is granted, active_src is loaded, note index is set to 0, and half_period plus duration are loaded.
  - PLAY → GAP after the note duration. tone_en goes 0 and half_period holds.
  - GAP → PLAY after GAP_MS, only when source is score and note index is 0. The note index becomes 1.
  - In all other cases GAP → IDLE after GAP_MS. active_src goes to 0.
- Notes, as half_period values:
  - wall: 440 Hz, 28408.
  - paddle: 880 Hz, 14204.
  - score note 0: 660 Hz, 18938.
  - score note 1: 330 Hz, 37877.
- Register values are cycles/2 − 1, because the tone generator toggles on count equal to the input and then restarts at 0.
- Ms-tick counter: counts 0..TICK_CYCLES−1 and restarts at 0 on every state entry. The duration counter decrements on each tick wrap. The state exits on the wrap that takes the counter to 0.
- Reset mid-sequence clears everything immediately. Pending requests are lost.

## Timing
- Reset values: half_period 0, tone_en 0, busy 0, active_src 0, all latches 0, state IDLE.
- Latency, for req high at edge k: the latch is set after edge k. At edge k+1 the state is PLAY and tone_en, busy, active_src and half_period are valid, all registered.
- Note length is exactly N×TICK_CYCLES cycles of tone_en high. Gap length is exactly GAP_MS×TICK_CYCLES cycles.
- Wall sound, measured from the first PLAY cycle: busy stays high for (WALL_MS+GAP_MS)×TICK_CYCLES cycles.
- Score sound: 2×(SCORE_MS+GAP_MS)×TICK_CYCLES busy cycles. tone_en is low for the first inter-note gap.
- GAP → IDLE takes one edge. A pending latch is granted on the following edge, so back-to-back events have one idle cycle between them with busy low.
- A request arriving in the same cycle as its grant stays pending and replays afterwards.
- Widths: tick counter is ceil(log2 TICK_CYCLES) bits. Duration counter is 8 bits, so all *_MS values must be ≤ 255.

## Structure
- sound_pkg holds:
  - note half-period constants, namely HP_WALL, HP_PADDLE, HP_SCORE0 and HP_SCORE1;
  - the source encoding, which gives the active_src values;
  - the FSM state encoding.
- One sub-module, ms_ticker: the restartable tick counter with a restart input and a tick pulse output.

## Test plan
All scenarios use TICK_CYCLES=4 and default *_MS values.
1. Reset then idle 100 cycles. Required: all outputs 0.
2. req_paddle pulse at edge 10. Required:
   - tone_en=1, half_period=14204 and active_src=2 from edge 11.
   - tone_en high 200 cycles, then 40 gap cycles, then busy=0.
3. Simultaneous req_wall, req_paddle and req_score pulses. Required:
   - Score plays first: 18938 for 600 cycles, gap 40, 37877 for 600 cycles, gap 40.
   - One idle cycle, then paddle, then wall.
4. req_wall held high for 3 cycles, then re-pulsed mid-note. Required: exactly two wall sequences.
5. req_score during a wall note. Required: the wall note completes unchanged, then score starts after one idle cycle.
6. Assert rst mid-score note. Required: outputs are 0 immediately (asynchronous). After release, nothing plays without a new request.
